// File: rtl/ldst_rs_sched.sv
// rtl/ldst_rs_sched.sv - in-order load/store reservation station and issue scheduler
module ldst_rs_sched #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic                     alloc_is_st,
    input  logic [2:0]               alloc_funct3,
    input  logic [ROB_W-1:0]         alloc_dest_rob,
    input  logic                     alloc_src1_valid,
    input  logic [31:0]              alloc_src1_val,
    input  logic [ROB_W-1:0]         alloc_src1_rob,
    input  logic                     alloc_src2_valid,
    input  logic [31:0]              alloc_src2_val,
    input  logic [ROB_W-1:0]         alloc_src2_rob,
    input  logic [31:0]              alloc_imm,
    input  logic                     cdb_valid,
    input  logic [ROB_W-1:0]         cdb_rob,
    input  logic [31:0]              cdb_val,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_is_st,
    output logic [2:0]               mem_funct3,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [ROB_W-1:0]         mem_dest_rob,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_is_st;
    logic [DEPTH-1:0] e_s1v;
    logic [DEPTH-1:0] e_s2v;
    logic [2:0]       e_funct3 [DEPTH];
    logic [ROB_W-1:0] e_dest   [DEPTH];
    logic [ROB_W-1:0] e_s1rob  [DEPTH];
    logic [ROB_W-1:0] e_s2rob  [DEPTH];
    logic [31:0]      e_s1val  [DEPTH];
    logic [31:0]      e_s2val  [DEPTH];
    logic [31:0]      e_imm    [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic head_valid;
    logic alloc_fire;
    logic issue_fire;
    logic s1_bypass;
    logic s2_bypass;

    // No bypass from issue: a full station refuses allocation even if the head leaves this cycle.
    assign alloc_ready = (count != FULL) & ~flush;
    assign alloc_fire  = alloc_valid & alloc_ready;

    // Issue readiness depends only on registered state, so a CDB value is seen one cycle later.
    assign head_valid    = e_valid[head];
    assign mem_req_valid = head_valid & e_s1v[head] & (~e_is_st[head] | e_s2v[head]);
    assign issue_fire    = mem_req_valid & mem_req_ready & ~flush;

    // Head fields are forced to zero when the station is empty so stale data never leaks out.
    assign mem_is_st    = head_valid & e_is_st[head];
    assign mem_funct3   = head_valid ? e_funct3[head] : 3'd0;
    assign mem_addr     = head_valid ? (e_s1val[head] + e_imm[head]) : 32'd0;
    assign mem_wdata    = head_valid ? e_s2val[head] : 32'd0;
    assign mem_dest_rob = head_valid ? e_dest[head] : '0;

    // An operand broadcast in the same cycle as its allocation is captured directly.
    assign s1_bypass = cdb_valid & ~alloc_src1_valid & (alloc_src1_rob == cdb_rob);
    assign s2_bypass = cdb_valid & ~alloc_src2_valid & (alloc_src2_rob == cdb_rob);

    // Entry storage, CDB wakeup, pointer and occupancy maintenance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid <= '0;
            e_is_st <= '0;
            e_s1v   <= '0;
            e_s2v   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_funct3[i] <= '0;
                e_dest[i]   <= '0;
                e_s1rob[i]  <= '0;
                e_s2rob[i]  <= '0;
                e_s1val[i]  <= '0;
                e_s2val[i]  <= '0;
                e_imm[i]    <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            e_valid <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && cdb_valid) begin
                    if (!e_s1v[i] && e_s1rob[i] == cdb_rob) begin
                        e_s1v[i]   <= 1'b1;
                        e_s1val[i] <= cdb_val;
                    end
                    if (!e_s2v[i] && e_s2rob[i] == cdb_rob) begin
                        e_s2v[i]   <= 1'b1;
                        e_s2val[i] <= cdb_val;
                    end
                end
            end
            if (issue_fire) begin
                e_valid[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            // The tail slot is never valid when allocation is allowed, so no wakeup collides here.
            if (alloc_fire) begin
                e_valid[tail]  <= 1'b1;
                e_is_st[tail]  <= alloc_is_st;
                e_funct3[tail] <= alloc_funct3;
                e_dest[tail]   <= alloc_dest_rob;
                e_s1v[tail]    <= alloc_src1_valid | s1_bypass;
                e_s1val[tail]  <= s1_bypass ? cdb_val : alloc_src1_val;
                e_s1rob[tail]  <= alloc_src1_rob;
                e_s2v[tail]    <= alloc_src2_valid | s2_bypass;
                e_s2val[tail]  <= s2_bypass ? cdb_val : alloc_src2_val;
                e_s2rob[tail]  <= alloc_src2_rob;
                e_imm[tail]    <= alloc_imm;
                tail           <= tail + 1'b1;
            end
            case ({alloc_fire, issue_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ldst_rs_sched.sv
// tb/tb_ldst_rs_sched.sv - randomized self-checking bench for ldst_rs_sched
module tb_ldst_rs_sched;

    localparam int DEPTH = 4;
    localparam int ROB_W = 5;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             alloc_valid;
    logic             alloc_ready;
    logic             alloc_is_st;
    logic [2:0]       alloc_funct3;
    logic [ROB_W-1:0] alloc_dest_rob;
    logic             alloc_src1_valid;
    logic [31:0]      alloc_src1_val;
    logic [ROB_W-1:0] alloc_src1_rob;
    logic             alloc_src2_valid;
    logic [31:0]      alloc_src2_val;
    logic [ROB_W-1:0] alloc_src2_rob;
    logic [31:0]      alloc_imm;
    logic             cdb_valid;
    logic [ROB_W-1:0] cdb_rob;
    logic [31:0]      cdb_val;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_is_st;
    logic [2:0]       mem_funct3;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [ROB_W-1:0] mem_dest_rob;
    logic [2:0]       count;

    ldst_rs_sched #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_is_st(alloc_is_st), .alloc_funct3(alloc_funct3),
        .alloc_dest_rob(alloc_dest_rob),
        .alloc_src1_valid(alloc_src1_valid), .alloc_src1_val(alloc_src1_val),
        .alloc_src1_rob(alloc_src1_rob),
        .alloc_src2_valid(alloc_src2_valid), .alloc_src2_val(alloc_src2_val),
        .alloc_src2_rob(alloc_src2_rob), .alloc_imm(alloc_imm),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_val(cdb_val),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_is_st(mem_is_st), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_dest_rob(mem_dest_rob), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_st;
        logic [2:0]  f3;
        logic [4:0]  rob;
        logic        s1v;
        logic [31:0] s1val;
        logic [4:0]  s1rob;
        logic        s2v;
        logic [31:0] s2val;
        logic [4:0]  s2rob;
        logic [31:0] imm;
    } ent_t;

    ent_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_issued = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic head_ready();
        if (q.size() == 0) return 1'b0;
        return q[0].s1v && (!q[0].is_st || q[0].s2v);
    endfunction

    task automatic idle_inputs();
        flush = 0; alloc_valid = 0; alloc_is_st = 0; alloc_funct3 = 0; alloc_dest_rob = 0;
        alloc_src1_valid = 0; alloc_src1_val = 0; alloc_src1_rob = 0;
        alloc_src2_valid = 0; alloc_src2_val = 0; alloc_src2_rob = 0; alloc_imm = 0;
        cdb_valid = 0; cdb_rob = 0; cdb_val = 0; mem_req_ready = 0;
    endtask

    task automatic set_alloc(input logic st, input logic [2:0] f3, input logic [4:0] rob,
                             input logic v1, input logic [31:0] val1, input logic [4:0] r1,
                             input logic v2, input logic [31:0] val2, input logic [4:0] r2,
                             input logic [31:0] imm);
        alloc_valid = 1; alloc_is_st = st; alloc_funct3 = f3; alloc_dest_rob = rob;
        alloc_src1_valid = v1; alloc_src1_val = val1; alloc_src1_rob = r1;
        alloc_src2_valid = v2; alloc_src2_val = val2; alloc_src2_rob = r2; alloc_imm = imm;
    endtask

    task automatic set_cdb(input logic v, input logic [4:0] rob, input logic [31:0] val);
        cdb_valid = v; cdb_rob = rob; cdb_val = val;
    endtask

    // Check outputs against the queue model, clock once, then advance the model.
    task automatic step();
        logic exp_ar, exp_rv, do_alloc, do_issue;
        ent_t e;
        #1;
        exp_ar = (q.size() < DEPTH) && !flush;
        exp_rv = head_ready();
        check("count", 32'(count), 32'(q.size()));
        check("alloc_ready", 32'(alloc_ready), 32'(exp_ar));
        check("mem_req_valid", 32'(mem_req_valid), 32'(exp_rv));
        if (q.size() == 0) begin
            check("empty_addr", mem_addr, 32'd0);
            check("empty_rob", 32'(mem_dest_rob), 32'd0);
        end else if (exp_rv) begin
            check("mem_addr", mem_addr, q[0].s1val + q[0].imm);
            check("mem_dest_rob", 32'(mem_dest_rob), 32'(q[0].rob));
            check("mem_is_st", 32'(mem_is_st), 32'(q[0].is_st));
            check("mem_funct3", 32'(mem_funct3), 32'(q[0].f3));
            if (q[0].is_st) check("mem_wdata", mem_wdata, q[0].s2val);
        end
        do_alloc = alloc_valid && exp_ar;
        do_issue = exp_rv && mem_req_ready && !flush;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            for (int i = 0; i < q.size(); i++) begin
                e = q[i];
                if (cdb_valid && !e.s1v && e.s1rob == cdb_rob) begin e.s1v = 1; e.s1val = cdb_val; end
                if (cdb_valid && !e.s2v && e.s2rob == cdb_rob) begin e.s2v = 1; e.s2val = cdb_val; end
                q[i] = e;
            end
            if (do_issue) begin
                void'(q.pop_front());
                n_issued++;
            end
            if (do_alloc) begin
                e.is_st = alloc_is_st; e.f3 = alloc_funct3; e.rob = alloc_dest_rob;
                e.s1v = alloc_src1_valid; e.s1val = alloc_src1_val; e.s1rob = alloc_src1_rob;
                e.s2v = alloc_src2_valid; e.s2val = alloc_src2_val; e.s2rob = alloc_src2_rob;
                e.imm = alloc_imm;
                if (cdb_valid && !e.s1v && e.s1rob == cdb_rob) begin e.s1v = 1; e.s1val = cdb_val; end
                if (cdb_valid && !e.s2v && e.s2rob == cdb_rob) begin e.s2v = 1; e.s2val = cdb_val; end
                q.push_back(e);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_addr", mem_addr, 32'd0);

        // Ready load issues the cycle after allocation.
        set_alloc(0, 3'd2, 5'd3, 1, 32'h1000, 0, 1, 0, 0, 32'h10); step();
        check("load_addr", mem_addr, 32'h1010);
        mem_req_ready = 1; step();
        check("load_drained", 32'(count), 32'd0);

        // Store waits for its data from the CDB.
        set_alloc(1, 3'd2, 5'd4, 1, 32'h2000, 0, 0, 0, 5'd7, 32'h8); step();
        step();
        set_cdb(1, 5'd7, 32'hDEADBEEF); step();
        check("st_wdata", mem_wdata, 32'hDEADBEEF);
        mem_req_ready = 1; step();

        // Same-cycle CDB capture at allocation.
        set_alloc(0, 3'd0, 5'd6, 0, 0, 5'd5, 1, 0, 0, 32'h4); set_cdb(1, 5'd5, 32'h40); step();
        check("bypass_addr", mem_addr, 32'h44);
        mem_req_ready = 1; step();

        // Fill with a blocked head; younger ready entries must wait.
        set_alloc(0, 3'd4, 5'd10, 0, 0, 5'd9, 1, 0, 0, 32'h0); step();
        for (int i = 0; i < 3; i++) begin
            set_alloc(0, 3'd1, 5'(11 + i), 1, 32'h100 * (i + 1), 0, 1, 0, 0, 32'h1);
            mem_req_ready = 1; step();
        end
        set_alloc(0, 3'd0, 5'd20, 1, 32'h5000, 0, 1, 0, 0, 0); mem_req_ready = 1; step();
        check("full_count", 32'(count), 32'd4);
        set_cdb(1, 5'd9, 32'h3000); step();
        set_alloc(0, 3'd0, 5'd21, 1, 32'h6000, 0, 1, 0, 0, 0); mem_req_ready = 1; step();
        check("full_issue_count", 32'(count), 32'd3);
        for (int i = 0; i < 2; i++) begin
            set_alloc(1, 3'd2, 5'(22 + i), 1, 32'h7000, 0, 1, 32'hA0 + i, 0, 32'h4); step();
        end
        for (int i = 0; i < 6; i++) begin mem_req_ready = 1; step(); end

        // Flush with queued work, competing alloc and issue.
        for (int i = 0; i < 3; i++) begin
            set_alloc(0, 3'd0, 5'(i), 1, 32'h10 * i, 0, 1, 0, 0, 0); step();
        end
        flush = 1; mem_req_ready = 1;
        set_alloc(0, 3'd0, 5'd30, 1, 0, 0, 1, 0, 0, 0); step();
        check("flush_count", 32'(count), 32'd0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 2; i++) begin
            set_alloc(0, 3'd0, 5'(i), 1, 32'h20, 0, 1, 0, 0, 0); step();
        end
        #2 rst_n = 0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_req_valid", 32'(mem_req_valid), 32'd0);
        rst_n = 1;
        q.delete();
        #1;
        check("arst_alloc_ready", 32'(alloc_ready), 32'd1);
        @(negedge clk);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) < 60)
                set_alloc(1'($urandom), 3'($urandom), 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 1) == 1), $urandom, 5'($urandom_range(0, 7)),
                          ($urandom_range(0, 1) == 1), $urandom, 5'($urandom_range(0, 7)),
                          $urandom);
            set_cdb(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
            mem_req_ready = ($urandom_range(0, 99) < 60);
            flush = ($urandom_range(0, 99) < 3);
            step();
        end
        check("issued_some", 32'(n_issued > 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ldst_rs_sched.md
Name: ldst_rs_sched

Overview:
- In-order reservation station and issue scheduler for the single load/store unit of the RV32IM out-of-order core.
- The instruction queue allocates ld/st entries into it, carrying source values or ROB tags.
- Entries wake up by snooping the CDB.
- The block issues the oldest entry to the memory port through a valid/ready handshake once its operands are ready, preserving program order for all memory operations.

Parameters:
- DEPTH, 4, number of RS entries; power of two, minimum 2.
- ROB_W, 5, ROB index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous squash of all entries (branch mispredict).
- alloc_valid  in  1  IQ presents a ld/st entry.
- alloc_ready  out  1  entry accepted this cycle when alloc_valid is also high.
- alloc_is_st  in  1  1 = store, 0 = load.
- alloc_funct3  in  3  RV32 load/store funct3.
- alloc_dest_rob  in  ROB_W  ROB index of the instruction.
- alloc_src1_valid  in  1  src1 value present.
- alloc_src1_val  in  32  base register value.
- alloc_src1_rob  in  ROB_W  producer tag when src1 is not valid.
- alloc_src2_valid  in  1  src2 value present (store data).
- alloc_src2_val  in  32  store data value.
- alloc_src2_rob  in  ROB_W  producer tag when src2 is not valid.
- alloc_imm  in  32  sign-extended offset.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_rob  in  ROB_W  broadcast ROB tag.
- cdb_val  in  32  broadcast value.
- mem_req_valid  out  1  head entry ready to issue.
- mem_req_ready  in  1  LSU accepts the request.
- mem_is_st  out  1  head entry type.
- mem_funct3  out  3  head entry funct3.
- mem_addr  out  32  src1_val + imm.
- mem_wdata  out  32  src2_val (meaningful for stores only).
- mem_dest_rob  out  ROB_W  head entry ROB index.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries with head and tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH.
  - Each entry holds: valid, is_st, funct3, dest_rob, src1 {valid, val, rob}, src2 {valid, val, rob}, imm.
- Reset (rst_n low, asynchronous):
  - All entry valid bits, head, tail and count go to 0.
  - Outputs: alloc_ready=1, mem_req_valid=0, count=0.
  - All other outputs are 0 while the block is empty.
  - Reset asserted mid-operation discards every entry with no issue.
- Allocation:
  - alloc_ready = (count < DEPTH) & ~flush.
  - There is no same-cycle bypass from issue: when full, alloc_ready stays 0 even if the head issues that cycle.
  - On handshake, the entry is written at tail and tail increments.
- Allocation wakeup bypass:
  - If cdb_valid and a source is not valid and its rob equals cdb_rob in the same cycle, that source is written valid with cdb_val.
- Wakeup:
  - Every cycle, each valid entry with srcN_valid=0 and srcN_rob==cdb_rob while cdb_valid=1 sets srcN_valid=1 and captures cdb_val.
  - The new operand is visible to issue on the next cycle; there is no combinational CDB-to-issue path.
- Issue readiness:
  - head_ready = entry[head].valid & src1_valid & (~is_st | src2_valid).
  - mem_req_valid = head_ready; it is combinational from registered state only.
  - Only the head may issue; younger ready entries wait, giving strict program order.
- Issue outputs:
  - mem_addr = src1_val + imm, 32-bit wrap-around with no overflow flag.
  - Outputs are driven from the head entry.
  - Once mem_req_valid rises, the outputs hold stable until the handshake or a flush.
- Issue handshake:
  - On mem_req_valid & mem_req_ready, the head entry is invalidated and head increments.
- Count update:
  - count += alloc handshake − issue handshake.
  - Simultaneous allocate and issue leaves count unchanged.
  - Both pointers advance in that case.
- Flush:
  - flush high at a clock edge clears all valid bits and sets head=tail=count=0.
  - Flush overrides any alloc or issue handshake in the same cycle: no issue is counted, and mem_req_valid may still be high that cycle but the LSU is told by flush to drop the request.
  - CDB captures during flush are discarded.
- Empty: mem_req_valid=0.
- Full: count=DEPTH, alloc_ready=0.

Test Plan:
- Reset, then allocate a load with src1_valid=1, src1_val=0x1000, imm=0x10, dest_rob=3 -> next cycle mem_req_valid=1, mem_addr=0x1010, mem_dest_rob=3, mem_is_st=0; with mem_req_ready=1, count goes 1->0.
- Allocate a store with src1 valid (0x2000), src2_rob=7 not valid; CDB broadcasts rob 7 with value 0xDEADBEEF two cycles later -> mem_req_valid goes high the cycle after the broadcast, mem_wdata=0xDEADBEEF, mem_addr=0x2000+imm.
- Allocate an entry with src1_rob=5 not valid while cdb_valid=1 and cdb_rob=5 with value 0x40 in the same cycle -> entry captured as valid; mem_req_valid=1 next cycle, mem_addr=0x40+imm.
- Fill 4 entries with the head blocked on an operand -> count=4, alloc_ready=0; a younger ready entry does not issue. Wake the head, issue with simultaneous alloc_valid -> alloc not accepted that cycle, count=3. Allocate 2 more over later cycles -> tail wraps, order preserved.
- Three entries queued, flush=1 with alloc_valid=1 and mem_req_ready=1 -> next cycle count=0, mem_req_valid=0, no entry accepted, no issue counted.
- Two entries queued, pulse rst_n low between clock edges -> count=0 and mem_req_valid=0 immediately (asynchronously); after release, alloc_ready=1.
